apb_key_in: RTL and testbench
=============================

# apb_key_in

APB read-side input peripheral: samples WIDTH external key/switch lines, synchronizes and debounces them, latches press events as sticky flags, and returns status to the CPU over APB read transfers. It is the input counterpart of the write-only APB LED output block and sits on the same APB segment of the e902 SoC peripheral bus. Zero-wait-state slave with an optional level interrupt to the interrupt controller.

## Interface
- WIDTH, 4: number of key inputs (1..16).
- DEB_CNT, 50000: consecutive stable cycles required before a debounced level changes (2..2^20-1).
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  4  byte address; only PADDR[3:2] decoded.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- KEY  input  WIDTH  raw asynchronous key levels, active-high (pressed = 1).
- IRQ  output  1  level interrupt = |(EDGE & MASK).

## Operation
- No PREADY/PSLVERR ports; every transfer completes in the access phase.
- Register map (word offsets; unused bits read 0, writes to them ignored):
  - 0x0 STATE, RO: debounced levels [WIDTH-1:0].
  - 0x4 EDGE, R/W1C: sticky press flags; write 1 to a bit clears it, 0 leaves it.
  - 0x8 MASK, RW: interrupt enables [WIDTH-1:0].
  - 0xC RAW, RO: synchronized (undebounced) levels [WIDTH-1:0].
- Write strobe: PSEL & PENABLE & PWRITE; register updates on that clock edge.
- PRDATA combinational: selected register when PSEL & !PWRITE, else 32'h0. Reads have no side effects.
- Per key: 2-flop synchronizer -> sync; 20-bit counter cnt; debounced level deb.
  - sync == deb: cnt <= 0.
  - sync != deb and cnt < DEB_CNT-1: cnt <= cnt+1.
  - sync != deb and cnt == DEB_CNT-1: deb <= sync, cnt <= 0.
  - Any glitch back to deb before terminal count restarts the count from 0.
- EDGE[i] set on the edge where deb[i] goes 0->1; release (1->0) sets nothing.
- Simultaneous set and W1C of the same EDGE bit: set wins (bit stays 1).
- MASK write and EDGE set in the same cycle: both take effect; IRQ follows next-state values.

## Timing
- Reset values: sync, cnt, deb, EDGE, MASK all 0; PRDATA 0 (PSEL low at reset); IRQ 0.
- KEY change captured at edge k -> RAW visible after edge k+1 -> deb/STATE and EDGE change at edge k+1+DEB_CNT, provided KEY stays stable.
- IRQ asserts combinationally from registered EDGE/MASK: same cycle EDGE or MASK updates, no extra latency.
- W1C clear takes effect at the access-phase edge; IRQ deasserts the following cycle if no other masked flag is set.
- Reset asserted mid-debounce: counter and levels clear immediately; after release a held key needs a full 2+DEB_CNT cycles to reappear and produces a new EDGE flag.
- Setup-phase (PENABLE=0) writes have no effect.

## Structure
- Package apb_key_pkg: register offsets (STATE/EDGE/MASK/RAW on PADDR[3:2]), DEB counter width (20), default DEB_CNT.
- Sub-module key_debounce (one instance per key via generate): synchronizer, counter, deb output, rise pulse output. Top holds APB decode, EDGE/MASK, PRDATA mux, IRQ.

## Test plan
- Reset: assert rst_n=0 with KEY=4'hF -> all reads 0, IRQ=0; release -> STATE=4'hF exactly 2+DEB_CNT cycles later (DEB_CNT=4: 6 cycles), EDGE=4'hF.
- Bounce: DEB_CNT=4, KEY[0] toggles 1,0,1 at 2-cycle spacing then holds 1 -> STATE[0] rises only 6 cycles after last toggle, EDGE[0] set once.
- W1C: EDGE=4'b0101, write 0x4 <= 32'h1 -> EDGE reads 4'b0100; write 0 -> unchanged.
- Collision: W1C of EDGE[1] in the same cycle deb[1] rises -> EDGE[1] reads 1.
- IRQ: MASK=4'b0010, press KEY[0] -> IRQ stays 0; press KEY[1] -> IRQ=1 same cycle EDGE[1] sets; W1C bit1 -> IRQ=0 next cycle.
- Decode: read 0x8 after writing 32'hFFFF_FFFF -> 32'h0000_000F; read with PSEL=0 -> 32'h0; setup-only write -> MASK unchanged.

Source files
------------

// File: rtl/apb_key_pkg.sv
// Shared constants for the APB key input peripheral: register selects
// decoded from PADDR[3:2], debounce counter width and default debounce length.
package apb_key_pkg;

    // Debounce counter width; supports DEB_CNT up to 2^20-1.
    localparam int DEB_W           = 20;
    localparam int DEB_CNT_DEFAULT = 50000;

    // Word-offset register selects on PADDR[3:2].
    typedef enum logic [1:0] {
        REG_STATE = 2'd0,  // debounced levels, read-only
        REG_EDGE  = 2'd1,  // sticky press flags, write-1-to-clear
        REG_MASK  = 2'd2,  // interrupt enables, read/write
        REG_RAW   = 2'd3   // synchronized undebounced levels, read-only
    } reg_sel_e;

    // Zero-extend a key-wide vector (at most 16 bits) onto the 32-bit bus.
    function automatic logic [31:0] zext16(input logic [15:0] val);
        return {16'h0, val};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchronizer, stability counter and debounced
// level. o_rise is high in the cycle whose closing edge moves deb 0->1, so
// the parent can set its sticky flag on that same edge.
module key_debounce
    import apb_key_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_sync,
    output logic o_deb,
    output logic o_rise
);

    localparam logic [DEB_W-1:0] TERM = DEB_W'(DEB_CNT - 1);

    logic             r_meta;
    logic             r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_deb;
    logic             w_term;

    assign w_term = (r_cnt == TERM);

    // Bring the asynchronous key level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_key;
            r_sync <= r_meta;
        end
    end

    // Count consecutive cycles the synchronized level disagrees with deb;
    // any agreement restarts the count, reaching terminal count adopts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync == r_deb) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_deb <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sync = r_sync;
    assign o_deb  = r_deb;
    assign o_rise = r_sync & ~r_deb & w_term;

endmodule

// File: rtl/apb_key_in.sv
// APB read-side key peripheral: per-key debounce channels, sticky press
// flags (W1C), interrupt mask, zero-wait-state read mux and level IRQ.
module apb_key_in
    import apb_key_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [3:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    input  logic [WIDTH-1:0] KEY,
    output logic             IRQ
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [15:0]      w_rsel;
    logic             w_wr;
    reg_sel_e         w_sel;
    logic             w_unused;

    // Byte-lane address bits and write data above WIDTH carry no meaning.
    assign w_unused = &{1'b0, PADDR[1:0], PWDATA[31:WIDTH]};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_key
            key_debounce #(
                .DEB_CNT (DEB_CNT)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_key  (KEY[gi]),
                .o_sync (w_sync[gi]),
                .o_deb  (w_deb[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_wr  = PSEL & PENABLE & PWRITE;
    assign w_sel = reg_sel_e'(PADDR[3:2]);
    assign w_clr = (w_wr && (w_sel == REG_EDGE)) ? PWDATA[WIDTH-1:0] : '0;

    // Sticky press flags: clear requested bits, then a new press wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
        end
    end

    // Interrupt enables, written only in the access phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (w_wr && (w_sel == REG_MASK)) begin
            r_mask <= PWDATA[WIDTH-1:0];
        end
    end

    // Read mux: the selected register while a read is addressed, else zero.
    always_comb begin
        w_rsel = '0;
        case (w_sel)
            REG_STATE: w_rsel[WIDTH-1:0] = w_deb;
            REG_EDGE:  w_rsel[WIDTH-1:0] = r_edge;
            REG_MASK:  w_rsel[WIDTH-1:0] = r_mask;
            REG_RAW:   w_rsel[WIDTH-1:0] = w_sync;
            default:   w_rsel = '0;
        endcase
    end

    assign PRDATA = (PSEL && !PWRITE) ? zext16(w_rsel) : 32'h0;
    assign IRQ    = |(r_edge & r_mask);

endmodule

// File: tb/tb_apb_key_in.sv
// Self-checking bench for apb_key_in (WIDTH=4, DEB_CNT=4): directed steps
// for reset, bounce, W1C, collision, IRQ and decode, then a randomized phase
// checked against a behavioural model of the key/flag rules.
module tb_apb_key_in;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic        clk;
    logic        rst_n;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [W-1:0] KEY;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    apb_key_in #(
        .WIDTH   (W),
        .DEB_CNT (DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .KEY     (KEY),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A key's debounced level adopts the synchronized level once that level
    // has been held for DEB cycles while differing from the debounced level.
    logic [W-1:0] m_s1, m_sync, m_deb, m_edge, m_mask;
    int           m_age [W];
    logic [W-1:0] m_deb_n, m_rise_n, m_edge_n, m_mask_n;
    int           m_age_n [W];
    logic         m_wr;

    always_comb begin
        m_deb_n  = m_deb;
        m_rise_n = '0;
        for (int i = 0; i < W; i++) begin
            m_age_n[i] = (m_s1[i] == m_sync[i]) ?
                         ((m_age[i] < 1000) ? m_age[i] + 1 : 1000) : 1;
            if (m_sync[i] != m_deb[i] && m_age[i] >= DEB) begin
                m_deb_n[i]  = m_sync[i];
                m_rise_n[i] = m_sync[i];
            end
        end
        m_wr     = PSEL & PENABLE & PWRITE;
        m_edge_n = m_edge;
        if (m_wr && PADDR[3:2] == 2'd1) m_edge_n = m_edge & ~PWDATA[W-1:0];
        m_edge_n = m_edge_n | m_rise_n;
        m_mask_n = (m_wr && PADDR[3:2] == 2'd2) ? PWDATA[W-1:0] : m_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1   <= '0;
            m_sync <= '0;
            m_deb  <= '0;
            m_edge <= '0;
            m_mask <= '0;
            for (int i = 0; i < W; i++) m_age[i] <= 0;
        end else begin
            m_s1   <= KEY;
            m_sync <= m_s1;
            m_deb  <= m_deb_n;
            m_edge <= m_edge_n;
            m_mask <= m_mask_n;
            for (int i = 0; i < W; i++) m_age[i] <= m_age_n[i];
        end
    end

    function automatic logic [31:0] model_reg(input logic [1:0] sel);
        case (sel)
            2'd0:    return {28'h0, m_deb};
            2'd1:    return {28'h0, m_edge};
            2'd2:    return {28'h0, m_mask};
            default: return {28'h0, m_sync};
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Combinational read inside the current cycle.
    task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = addr;
        #1;
        check(tag, PRDATA, exp);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Count edges until (STATE & mask) == val; 20 edges is the bound.
    task automatic count_state(input string tag, input logic [3:0] msk,
                               input logic [3:0] val, input int exp_cyc);
        int c;
        c = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
        for (int k = 0; k < 20; k++) begin
            tick();
            c++;
            if ((PRDATA[3:0] & msk) == val) break;
            if (k == 19) c = 99;
        end
        PSEL = 1'b0;
        check(tag, c, exp_cyc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 4'h0; PWDATA = 32'h0; KEY = 4'hF;

        // Reset with all keys held.
        ticks(3);
        read_chk("rst_state", 4'h0, 32'h0);
        read_chk("rst_edge",  4'h4, 32'h0);
        read_chk("rst_mask",  4'h8, 32'h0);
        read_chk("rst_raw",   4'hC, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        rst_n = 1'b1;
        count_state("rst_release_latency", 4'hF, 4'hF, 2 + DEB);
        read_chk("rst_release_edge", 4'h4, 32'hF);

        // Bounce on KEY[0].
        KEY = 4'h0;
        ticks(10);
        apb_write(4'h4, 32'hF);
        KEY = 4'h1; ticks(2);
        KEY = 4'h0; ticks(2);
        KEY = 4'h1;
        count_state("bounce_latency", 4'h1, 4'h1, 2 + DEB);
        read_chk("bounce_edge", 4'h4, 32'h1);

        // W1C behaviour.
        KEY = 4'h0;
        ticks(10);
        apb_write(4'h4, 32'hF);
        KEY = 4'h5;
        ticks(10);
        read_chk("w1c_pre",   4'h4, 32'h5);
        apb_write(4'h4, 32'h1);
        read_chk("w1c_bit0",  4'h4, 32'h4);
        apb_write(4'h4, 32'h0);
        read_chk("w1c_zero",  4'h4, 32'h4);

        // Collision: deb[1] rises 6 edges after this change; the write's
        // access edge is the 6th edge from here as well.
        KEY = 4'h7;
        ticks(4);
        apb_write(4'h4, 32'h2);
        read_chk("collide_edge",  4'h4, 32'h6);
        read_chk("collide_state", 4'h0, 32'h7);

        // IRQ masking and clearing.
        KEY = 4'h0;
        ticks(10);
        apb_write(4'h4, 32'hF);
        apb_write(4'h8, 32'h2);
        KEY = 4'h1;
        c = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (IRQ) c++;
        end
        check("irq_masked_key0", c, 0);
        read_chk("irq_edge0", 4'h4, 32'h1);
        KEY = 4'h3;
        c = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            c++;
            if (IRQ) break;
            if (k == 19) c = 99;
        end
        check("irq_latency", c, 2 + DEB);
        read_chk("irq_same_cycle_edge", 4'h4, 32'h3);
        apb_write(4'h4, 32'h2);
        check("irq_after_w1c", {31'h0, IRQ}, 32'h0);
        read_chk("irq_after_w1c_edge", 4'h4, 32'h1);

        // Decode.
        apb_write(4'h8, 32'hFFFF_FFFF);
        read_chk("mask_all_ones", 4'h8, 32'hF);
        PSEL = 1'b0; PWRITE = 1'b0; PADDR = 4'h8;
        #1;
        check("read_psel0", PRDATA, 32'h0);
        PSEL = 1'b1; PWRITE = 1'b1;
        #1;
        check("read_pwrite1", PRDATA, 32'h0);
        PENABLE = 1'b0; PWDATA = 32'h0;
        tick();
        PSEL = 1'b0; PWRITE = 1'b0;
        read_chk("setup_only_write", 4'h8, 32'hF);
        apb_write(4'h0, 32'h0);
        read_chk("state_ro", 4'h0, 32'h3);

        // Reset in the middle of a debounce.
        KEY = 4'h0;
        ticks(10);
        KEY = 4'h1;
        ticks(3);
        rst_n = 1'b0;
        #1;
        read_chk("midrst_state", 4'h0, 32'h0);
        read_chk("midrst_raw",   4'hC, 32'h0);
        check("midrst_irq", {31'h0, IRQ}, 32'h0);
        tick();
        rst_n = 1'b1;
        count_state("midrst_latency", 4'h1, 4'h1, 2 + DEB);
        read_chk("midrst_edge", 4'h4, 32'h1);

        // Randomized phase against the model.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    if ($urandom_range(0, 1) == 1) KEY = 4'($urandom);
                    for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                        tick();
                        check("rand_irq", {31'h0, IRQ}, {31'h0, |(m_edge & m_mask)});
                    end
                end
                2: begin
                    logic [1:0] s;
                    s = 2'($urandom);
                    read_chk("rand_read", {s, 2'b00}, model_reg(s));
                end
                default: begin
                    logic [1:0] s;
                    s = 2'($urandom);
                    apb_write({s, 2'($urandom)}, $urandom);
                    check("rand_wr_irq", {31'h0, IRQ}, {31'h0, |(m_edge & m_mask)});
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
